// File: rtl/sp_ram_req_ctrl_if.sv
// Request/response handshake bundle between a client and sp_ram_req_ctrl.
// The master issues requests and consumes read responses; the slave is the controller.
interface sp_ram_req_ctrl_if #(
  parameter int ADR_BIT = 4,
  parameter int DAT_BIT = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADR_BIT-1:0] req_addr;
  logic [DAT_BIT-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DAT_BIT-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sp_ram_req_ctrl.sv
// Front-end for a single-port synchronous RAM: clears the RAM after reset, then maps a
// valid/ready read/write stream onto the RAM port with a 2-entry read response buffer.
module sp_ram_req_ctrl #(
  parameter int               ADR_BIT  = 4,
  parameter int               DAT_BIT  = 32,
  parameter bit               INIT_EN  = 1'b1,
  parameter logic [DAT_BIT-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  sp_ram_req_ctrl_if.slave   bus,
  output logic               init_done,
  output logic               ram_en,
  output logic [ADR_BIT-1:0] ram_addr,
  output logic [DAT_BIT-1:0] ram_w_data,
  input  logic [DAT_BIT-1:0] ram_r_data
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t             ST_RESET = INIT_EN ? ST_INIT : ST_RUN;
  localparam logic [ADR_BIT-1:0] LAST_ADR = '1;

  state_t             state;
  logic [ADR_BIT-1:0] init_cnt;

  logic [DAT_BIT-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         fifo_cnt;
  logic               rd_inflight;

  logic               running;
  logic               pop;
  logic               accept;
  logic [2:0]         occupancy;

  // Combinational outputs are masked by rst_n so they show reset values while reset is held.
  assign running   = rst_n && (state == ST_RUN);
  assign init_done = (state == ST_RUN);

  assign bus.rsp_valid = (fifo_cnt != 2'd0);
  // NOTE: the two storage words are never reset; masking the head with rsp_valid is what
  // guarantees rsp_rdata reads 0 out of reset and whenever the buffer is empty.
  assign bus.rsp_rdata = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;

  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign occupancy     = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
  assign bus.req_ready = running && (occupancy < 3'd2);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    ram_en     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    if (rst_n && state == ST_INIT) begin
      ram_en     = 1'b1;
      ram_addr   = init_cnt;
      ram_w_data = INIT_VAL;
    end else if (running) begin
      ram_en     = accept && bus.req_we;
      ram_addr   = bus.req_addr;
      ram_w_data = bus.req_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_ADR) state <= ST_RUN;
    end
  end

  // A read accepted this cycle has its RAM data on ram_r_data next cycle, pushed then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      rd_inflight <= accept && !bus.req_we;
      if (rd_inflight) wr_ptr <= ~wr_ptr;
      if (pop)         rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rd_inflight) fifo_mem[wr_ptr] <= ram_r_data;
  end

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Bench for sp_ram_req_ctrl: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based model of the request stream.
module tb_sp_ram_req_ctrl;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] INIT_VAL = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_ram_req_ctrl_if #(.ADR_BIT(4), .DAT_BIT(32)) bus ();
  sp_ram_req_ctrl_if #(.ADR_BIT(4), .DAT_BIT(32)) bus0 ();

  logic        init_done, ram_en;
  logic [3:0]  ram_addr;
  logic [31:0] ram_w_data, ram_r_data;
  logic        init_done0, ram_en0;
  logic [3:0]  ram_addr0;
  logic [31:0] ram_w_data0, ram_r_data0;
  assign ram_r_data0 = '0;

  sp_ram_req_ctrl #(.ADR_BIT(4), .DAT_BIT(32), .INIT_EN(1'b1), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  sp_ram_req_ctrl #(.ADR_BIT(4), .DAT_BIT(32), .INIT_EN(1'b0), .INIT_VAL(INIT_VAL)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .init_done(init_done0), .ram_en(ram_en0),
    .ram_addr(ram_addr0), .ram_w_data(ram_w_data0), .ram_r_data(ram_r_data0)
  );

  // Synchronous-read RAM attached to the main instance.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) ram_mem[ram_addr] <= ram_w_data;
    ram_r_data <= ram_mem[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a read's data is fixed at accept time and becomes visible two cycles later;
  // everything accepted but not yet consumed counts toward the limit of two.
  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t         exp_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] got_q[$];
  int          cyc    = 0;
  int          dut_os = 0;

  always @(negedge clk) begin : compare
    bit m_valid, pop, exp_ready, accept;
    check("noinit_init_done", 32'(init_done0), 32'd1);
    check("noinit_ram_en", 32'(ram_en0), 32'd0);
    check("noinit_req_ready", 32'(bus0.req_ready), 32'(rst_n));
    if (!rst_n) begin
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_w_data", ram_w_data, 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      exp_q.delete();
      cyc    = 0;
      dut_os = 0;
    end else if (cyc < DEPTH) begin
      check("init_ram_en", 32'(ram_en), 32'd1);
      check("init_ram_addr", 32'(ram_addr), 32'(cyc));
      check("init_ram_w_data", ram_w_data, INIT_VAL);
      check("init_req_ready", 32'(bus.req_ready), 32'd0);
      check("init_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("init_init_done", 32'(init_done), 32'd0);
      m_mem[cyc[3:0]] = INIT_VAL;
      cyc++;
    end else begin
      m_valid   = exp_q.size() > 0 && exp_q[0].due <= cyc;
      pop       = m_valid && bus.rsp_ready;
      exp_ready = (exp_q.size() - int'(pop)) < 2;
      accept    = bus.req_valid && exp_ready;
      check("run_init_done", 32'(init_done), 32'd1);
      check("run_req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("run_ram_en", 32'(ram_en), 32'(accept && bus.req_we));
      check("run_ram_addr", 32'(ram_addr), 32'(bus.req_addr));
      check("run_ram_w_data", ram_w_data, bus.req_wdata);
      check("run_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      if (m_valid) check("run_rsp_rdata", bus.rsp_rdata, exp_q[0].data);
      if (bus.rsp_valid && bus.rsp_ready) got_q.push_back(bus.rsp_rdata);
      dut_os += int'(bus.req_valid && bus.req_ready && !bus.req_we)
              - int'(bus.rsp_valid && bus.rsp_ready);
      check("no_push_when_full", 32'(dut_os <= 2), 32'd1);
      if (pop) void'(exp_q.pop_front());
      if (accept) begin
        if (bus.req_we) m_mem[bus.req_addr] = bus.req_wdata;
        else            exp_q.push_back('{m_mem[bus.req_addr], cyc + 2});
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("req_accept_timeout", 32'd0, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (got_q.size() < n && k < 40) begin
      tick();
      k++;
    end
    check("rsp_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic init_seq();
    int hits = 0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      @(negedge clk);
      if (k < DEPTH) begin
        if (ram_en && ram_addr == 4'(k) && !init_done && !bus.req_ready) hits++;
      end else begin
        check("init_done_cycle16", 32'(init_done), 32'd1);
        check("req_ready_cycle16", 32'(bus.req_ready), 32'd1);
      end
    end
    check("init_write_cycles", 32'(hits), 32'd16);
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'hA5A5_0000 | 32'(i);
      m_mem[i]   = '0;
    end
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b1;

    // Power-up reset, then interrupt INIT at cycle 5.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("init_addr_cycle5", 32'(ram_addr), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ram_en", 32'(ram_en), 32'd0);
    check("async_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    init_seq();

    // Cleared contents are visible.
    got_q.delete();
    do_req(1'b0, 4'd7, '0);
    wait_rsp(1);
    if (got_q.size() >= 1) check("read_after_init", got_q[0], 32'hDEAD_BEEF);

    // Write then read the same address on the next cycle; data two cycles after accept.
    do_req(1'b1, 4'd3, 32'h1234_5678);
    do_req(1'b0, 4'd3, '0);
    @(negedge clk);
    check("raw_latency_n1_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("raw_latency_n2_valid", 32'(bus.rsp_valid), 32'd1);
    check("raw_latency_n2_data", bus.rsp_rdata, 32'h1234_5678);
    tick();

    // Backpressure: only two reads outstanding while rsp_ready is low.
    do_req(1'b1, 4'd1, 32'h11);
    do_req(1'b1, 4'd2, 32'h22);
    do_req(1'b1, 4'd3, 32'h33);
    tick();
    got_q.delete();
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 4'd1, '0);
    do_req(1'b0, 4'd2, '0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 4'd3, '0);
    wait_rsp(3);
    if (got_q.size() >= 3) begin
      check("bp_order_0", got_q[0], 32'h11);
      check("bp_order_1", got_q[1], 32'h22);
      check("bp_order_2", got_q[2], 32'h33);
    end

    // Sustained read stream with the consumer always ready.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 4'(i), 32'h1000 + 32'(i));
    tick();
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 4'(i);
      @(negedge clk);
      check("stream_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end
    bus.req_valid = 1'b0;
    wait_rsp(DEPTH);
    if (got_q.size() >= DEPTH)
      for (int i = 0; i < DEPTH; i++) check("stream_data", got_q[i], 32'h1000 + 32'(i));

    // Random traffic with a reset in the middle; the compare process checks every cycle.
    for (int n = 0; n < 1500; n++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = 4'($urandom_range(0, 15));
      bus.req_wdata = $urandom;
      bus.rsp_ready = ($urandom_range(0, 7) < ((n < 400) ? 2 : 6));
      if (n == 700) rst_n = 1'b0;
      if (n == 702) rst_n = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
